// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time and
// hands fetched words to decode, honouring decode stalls and execute redirects.
package constants_pkg;
   parameter int ARCH_LEN = 32;

   typedef struct packed {
      logic        valid;
      logic [31:0] inst;
   } inst_fetched_t;
endpackage

module instruction_fetch
   import constants_pkg::inst_fetched_t;
#(
   parameter int                  ARCH_LEN = constants_pkg::ARCH_LEN,
   parameter logic [ARCH_LEN-1:0] RESET_PC = ARCH_LEN'(32'h0000_1000)
) (
   input  logic                clk,
   input  logic                rst,
   output logic                imem_req_valid,
   input  logic                imem_req_ready,
   output logic [ARCH_LEN-1:0] imem_req_addr,
   input  logic                imem_rsp_valid,
   input  logic [31:0]         imem_rsp_data,
   input  logic                load_to_use_hazard,
   input  logic                branch_taken,
   input  logic [ARCH_LEN-1:0] branch_target,
   output inst_fetched_t       inst_fetched_out,
   output logic [ARCH_LEN-1:0] pc_out
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD
   } state_t;

   localparam logic [ARCH_LEN-1:0] INC = ARCH_LEN'(4);

   state_t              state_q, state_d;
   logic [ARCH_LEN-1:0] pc_q, pc_d;
   logic [ARCH_LEN-1:0] req_addr_q, req_addr_d;
   logic                kill_q, kill_d;
   logic [31:0]         hold_buf_q, hold_buf_d;
   logic [ARCH_LEN-1:0] hold_pc_q, hold_pc_d;
   inst_fetched_t       out_q, out_d;
   logic [ARCH_LEN-1:0] pc_out_q, pc_out_d;
   logic [ARCH_LEN-1:0] target_aligned;
   logic                out_free;

   assign target_aligned = branch_target & ~ARCH_LEN'(3);
   assign out_free       = !out_q.valid || !load_to_use_hazard;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
         kill_q     <= 1'b0;
         hold_buf_q <= '0;
         hold_pc_q  <= RESET_PC;
         out_q      <= '0;
         pc_out_q   <= RESET_PC;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         kill_q     <= kill_d;
         hold_buf_q <= hold_buf_d;
         hold_pc_q  <= hold_pc_d;
         out_q      <= out_d;
         pc_out_q   <= pc_out_d;
      end
   end

   // NOTE: every signal driven here gets a hold-value default first, so no
   // path through the case statement can leave one unassigned (no latches).
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      kill_d     = kill_q;
      hold_buf_d = hold_buf_q;
      hold_pc_d  = hold_pc_q;
      out_d      = out_q;
      pc_out_d   = pc_out_q;

      // Decode consumes the output whenever it is not stalled; a redirect
      // flushes it regardless of the stall.
      if (!load_to_use_hazard) out_d.valid = 1'b0;
      if (branch_taken) begin
         out_d.valid = 1'b0;
         pc_d        = target_aligned;
      end

      unique case (state_q)
         S_IDLE: begin
            state_d    = S_REQ;
            req_addr_d = branch_taken ? target_aligned : pc_q;
         end
         S_REQ: begin
            // The request already on the bus must finish; its response is dropped.
            if (branch_taken) kill_d = 1'b1;
            if (imem_req_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (branch_taken) begin
               if (imem_rsp_valid) begin
                  kill_d     = 1'b0;
                  state_d    = S_REQ;
                  req_addr_d = target_aligned;
               end else begin
                  kill_d = 1'b1;
               end
            end else if (imem_rsp_valid) begin
               if (kill_q) begin
                  kill_d     = 1'b0;
                  state_d    = S_REQ;
                  req_addr_d = pc_q;
               end else if (out_free) begin
                  out_d.valid = 1'b1;
                  out_d.inst  = imem_rsp_data;
                  pc_out_d    = req_addr_q + INC;
                  pc_d        = pc_q + INC;
                  req_addr_d  = pc_q + INC;
                  state_d     = S_REQ;
               end else begin
                  hold_buf_d = imem_rsp_data;
                  hold_pc_d  = req_addr_q + INC;
                  state_d    = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (branch_taken) begin
               state_d    = S_REQ;
               req_addr_d = target_aligned;
            end else if (!load_to_use_hazard) begin
               out_d.valid = 1'b1;
               out_d.inst  = hold_buf_q;
               pc_out_d    = hold_pc_q;
               pc_d        = pc_q + INC;
               req_addr_d  = pc_q + INC;
               state_d     = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign imem_req_valid   = (state_q == S_REQ);
   assign imem_req_addr    = req_addr_q;
   assign inst_fetched_out = out_q;
   assign pc_out           = pc_out_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed stimulus pushes expected
// requests/outputs into queues; a negedge monitor pops and compares them.
module tb_instruction_fetch;
   import constants_pkg::*;

   logic          clk;
   logic          rst;
   logic          imem_req_valid;
   logic          imem_req_ready;
   logic [31:0]   imem_req_addr;
   logic          imem_rsp_valid;
   logic [31:0]   imem_rsp_data;
   logic          load_to_use_hazard;
   logic          branch_taken;
   logic [31:0]   branch_target;
   inst_fetched_t inst_fetched_out;
   logic [31:0]   pc_out;

   int n_checks = 0;
   int n_fail   = 0;
   int mem_lat  = 1;

   logic [31:0] exp_req[$];
   logic [63:0] exp_out[$];

   instruction_fetch dut (
      .clk               (clk),
      .rst               (rst),
      .imem_req_valid    (imem_req_valid),
      .imem_req_ready    (imem_req_ready),
      .imem_req_addr     (imem_req_addr),
      .imem_rsp_valid    (imem_rsp_valid),
      .imem_rsp_data     (imem_rsp_data),
      .load_to_use_hazard(load_to_use_hazard),
      .branch_taken      (branch_taken),
      .branch_target     (branch_target),
      .inst_fetched_out  (inst_fetched_out),
      .pc_out            (pc_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_1000) return 32'h0050_0093;
      return {~a[15:0], a[15:0]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic check_reset_values();
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_req_addr", imem_req_addr, 32'h0000_1000);
      check("rst_out_valid", 32'(inst_fetched_out.valid), 32'd0);
      check("rst_out_inst", inst_fetched_out.inst, 32'd0);
      check("rst_pc_out", pc_out, 32'h0000_1000);
   endtask

   // Asserts reset mid-cycle, checks outputs before any clock edge, then
   // holds reset across two edges and returns just after a rising edge.
   task automatic do_reset();
      #2 rst = 1'b0;
      #1 check_reset_values();
      step();
      step();
   endtask

   // One-request memory with programmable latency; cleared by reset.
   initial begin : memory
      logic        take;
      logic        busy;
      logic [31:0] take_addr;
      logic [31:0] busy_addr;
      int          wait_c;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      busy           = 1'b0;
      busy_addr      = '0;
      wait_c         = 0;
      forever begin
         @(negedge clk);
         take      = imem_req_valid && imem_req_ready;
         take_addr = imem_req_addr;
         @(posedge clk);
         #1;
         imem_rsp_valid = 1'b0;
         if (!rst) begin
            busy = 1'b0;
         end else begin
            if (take) begin
               busy      = 1'b1;
               busy_addr = take_addr;
               wait_c    = mem_lat - 1;
            end
            if (busy) begin
               if (wait_c == 0) begin
                  imem_rsp_valid = 1'b1;
                  imem_rsp_data  = mem_word(busy_addr);
                  busy           = 1'b0;
               end else begin
                  wait_c--;
               end
            end
         end
      end
   end

   // A held output (valid under a stall) is the same instruction, not a new one.
   initial begin : monitor
      logic        last_valid;
      logic        last_hazard;
      logic [63:0] eo;
      last_valid  = 1'b0;
      last_hazard = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            last_valid  = 1'b0;
            last_hazard = 1'b0;
         end else begin
            if (imem_req_valid && imem_req_ready) begin
               if (exp_req.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_req: got addr %h, expected no request", imem_req_addr);
               end else begin
                  check("req_addr", imem_req_addr, exp_req.pop_front());
               end
            end
            if (inst_fetched_out.valid && !(last_valid && last_hazard)) begin
               if (exp_out.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_out: got inst %h pc_out %h, expected no output",
                           inst_fetched_out.inst, pc_out);
               end else begin
                  eo = exp_out.pop_front();
                  check("out_inst", inst_fetched_out.inst, eo[63:32]);
                  check("out_pc", pc_out, eo[31:0]);
               end
            end
            last_valid  = inst_fetched_out.valid;
            last_hazard = load_to_use_hazard;
         end
      end
   end

   initial begin : watchdog
      #20000;
      $display("FAIL watchdog: got timeout, expected test end");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      rst                = 1'b1;
      imem_req_ready     = 1'b0;
      load_to_use_hazard = 1'b0;
      branch_taken       = 1'b0;
      branch_target      = '0;

      do_reset();

      // Phase A: first fetch latency, request stall, decode stall with HOLD.
      exp_req.push_back(32'h0000_1000);
      exp_req.push_back(32'h0000_1004);
      exp_req.push_back(32'h0000_1008);
      exp_out.push_back({32'h0050_0093, 32'h0000_1004});
      exp_out.push_back({32'hEFFB_1004, 32'h0000_1008});
      exp_out.push_back({32'hEFF7_1008, 32'h0000_100C});
      imem_req_ready = 1'b1;
      rst            = 1'b1;
      step();                                   // cycle 1
      check("c1_req_valid", 32'(imem_req_valid), 32'd1);
      check("c1_req_addr", imem_req_addr, 32'h0000_1000);
      step();                                   // cycle 2
      check("c2_out_valid", 32'(inst_fetched_out.valid), 32'd0);
      step();                                   // cycle 3
      check("c3_out_valid", 32'(inst_fetched_out.valid), 32'd1);
      imem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin         // cycles 3..5
         check("stall_req_valid", 32'(imem_req_valid), 32'd1);
         check("stall_req_addr", imem_req_addr, 32'h0000_1004);
         step();
      end
      imem_req_ready = 1'b1;                    // cycle 6: accepted
      step();                                   // cycle 7: WAIT
      check("c7_req_valid", 32'(imem_req_valid), 32'd0);
      step();                                   // cycle 8
      check("c8_out_valid", 32'(inst_fetched_out.valid), 32'd1);
      load_to_use_hazard = 1'b1;
      step();                                   // cycle 9
      for (int i = 0; i < 3; i++) begin         // cycles 9..11
         check("hz_out_valid", 32'(inst_fetched_out.valid), 32'd1);
         check("hz_out_inst", inst_fetched_out.inst, 32'hEFFB_1004);
         check("hz_pc_out", pc_out, 32'h0000_1008);
         check("hz_req_valid", 32'(imem_req_valid), 32'd0);
         step();
      end
      load_to_use_hazard = 1'b0;                // cycle 12
      check("c12_req_valid", 32'(imem_req_valid), 32'd0);
      step();                                   // cycle 13
      check("c13_out_valid", 32'(inst_fetched_out.valid), 32'd1);
      check("c13_pc_out", pc_out, 32'h0000_100C);
      imem_req_ready = 1'b0;
      step();

      do_reset();

      // Phase B: redirects in WAIT, with response under stall, in REQ, and wrap.
      exp_req.push_back(32'h0000_1000);
      exp_req.push_back(32'h0000_1004);
      exp_req.push_back(32'h0000_1008);
      exp_req.push_back(32'h0000_2000);
      exp_req.push_back(32'h0000_2004);
      exp_req.push_back(32'h0000_3000);
      exp_req.push_back(32'h0000_3004);
      exp_req.push_back(32'hFFFF_FFFC);
      exp_req.push_back(32'h0000_0000);
      exp_out.push_back({32'h0050_0093, 32'h0000_1004});
      exp_out.push_back({32'hEFFB_1004, 32'h0000_1008});
      exp_out.push_back({32'hDFFF_2000, 32'h0000_2004});
      exp_out.push_back({32'hCFFF_3000, 32'h0000_3004});
      exp_out.push_back({32'h0003_FFFC, 32'h0000_0000});
      mem_lat        = 1;
      imem_req_ready = 1'b1;
      rst            = 1'b1;
      steps(5);                                 // cycle 5: REQ 0x1008
      check("b5_out_valid", 32'(inst_fetched_out.valid), 32'd1);
      mem_lat = 3;
      step();                                   // cycle 6: WAIT 0x1008
      branch_taken  = 1'b1;
      branch_target = 32'h0000_2002;
      check("b6_req_valid", 32'(imem_req_valid), 32'd0);
      step();                                   // cycle 7
      branch_taken = 1'b0;
      mem_lat      = 1;
      check("b7_out_valid", 32'(inst_fetched_out.valid), 32'd0);
      step();                                   // cycle 8: killed response
      check("b8_req_valid", 32'(imem_req_valid), 32'd0);
      step();                                   // cycle 9
      check("b9_req_valid", 32'(imem_req_valid), 32'd1);
      check("b9_req_addr", imem_req_addr, 32'h0000_2000);
      steps(2);                                 // cycle 11
      check("b11_out_valid", 32'(inst_fetched_out.valid), 32'd1);
      load_to_use_hazard = 1'b1;
      step();                                   // cycle 12: rsp + redirect
      branch_taken  = 1'b1;
      branch_target = 32'h0000_3000;
      check("b12_out_held", 32'(inst_fetched_out.valid), 32'd1);
      step();                                   // cycle 13
      branch_taken       = 1'b0;
      load_to_use_hazard = 1'b0;
      check("b13_out_valid", 32'(inst_fetched_out.valid), 32'd0);
      check("b13_req_addr", imem_req_addr, 32'h0000_3000);
      steps(2);                                 // cycle 15: REQ 0x3004
      branch_taken  = 1'b1;
      branch_target = 32'hFFFF_FFFC;
      step();                                   // cycle 16
      branch_taken = 1'b0;
      check("b16_out_valid", 32'(inst_fetched_out.valid), 32'd0);
      step();                                   // cycle 17
      check("b17_req_addr", imem_req_addr, 32'hFFFF_FFFC);
      steps(2);                                 // cycle 19
      check("b19_out_valid", 32'(inst_fetched_out.valid), 32'd1);
      check("b19_req_addr", imem_req_addr, 32'h0000_0000);
      mem_lat = 3;
      step();                                   // cycle 20: WAIT 0x0
      check("b20_req_valid", 32'(imem_req_valid), 32'd0);

      do_reset();

      // Fetch resumes cleanly from the reset PC.
      exp_req.push_back(32'h0000_1000);
      exp_out.push_back({32'h0050_0093, 32'h0000_1004});
      mem_lat        = 1;
      imem_req_ready = 1'b1;
      rst            = 1'b1;
      steps(3);
      check("r3_out_valid", 32'(inst_fetched_out.valid), 32'd1);
      imem_req_ready = 1'b0;
      steps(2);

      check("exp_req_left", 32'(exp_req.size()), 32'd0);
      check("exp_out_left", 32'(exp_out.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
